// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: register numbers, ID/EX control-word layout
// and ALU operation encodings.
package cpu_pkg;

  localparam logic [4:0] XZR = 5'd31;

  localparam int CTRL_W          = 8;
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_MEM_READ   = 5;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_ALU_OP_LSB = 0;

  typedef enum logic [2:0] {
    ALU_OP_ADD   = 3'd0,
    ALU_OP_SUB   = 3'd1,
    ALU_OP_RTYPE = 3'd2,
    ALU_OP_PASSB = 3'd3,
    ALU_OP_AND   = 3'd4,
    ALU_OP_ORR   = 3'd5,
    ALU_OP_EOR   = 3'd6,
    ALU_OP_LSL   = 3'd7
  } alu_op_e;

  // Bit order matches the CTRL_* indices above, MSB first.
  typedef struct packed {
    logic    reg_write;
    logic    mem_write;
    logic    mem_read;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the instruction in EX
// (a load) and the instruction being decoded in ID.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       flush,
  output logic       stall
);

  logic hazard;

  // A load into XZR produces nothing to wait for, so reads of register 31
  // can never match a real producer.
  assign hazard = ex_valid & ex_mem_read & (ex_rd != XZR) & id_valid &
                  ((ex_rd == id_rn) | (ex_rd == id_rm));

  // A squash discards the ID instruction anyway, so it never needs to wait.
  assign stall = hazard & ~flush;

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion
// on stall/flush/empty slots, and saturating stall/flush event counters.
module id_ex_hazard_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_valid,
  input  logic [4:0]        ID_Rn,
  input  logic [4:0]        ID_Rm,
  input  logic [4:0]        ID_Rd,
  input  logic [7:0]        ID_ctrl,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic              flush,
  output logic              IDEX_valid,
  output logic [4:0]        IDEX_Rn,
  output logic [4:0]        IDEX_Rm,
  output logic [4:0]        IDEX_Rd,
  output logic [7:0]        IDEX_ctrl,
  output logic [DATA_W-1:0] IDEX_ReadData1,
  output logic [DATA_W-1:0] IDEX_ReadData2,
  output logic [DATA_W-1:0] IDEX_Imm,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic bubble;

  load_use_detect u_load_use_detect (
    .ex_valid    (IDEX_valid),
    .ex_mem_read (IDEX_ctrl[CTRL_MEM_READ]),
    .ex_rd       (IDEX_Rd),
    .id_valid    (ID_valid),
    .id_rn       (ID_Rn),
    .id_rm       (ID_Rm),
    .flush       (flush),
    .stall       (stall)
  );

  // A bubble clears MemRead, so the same IF/ID contents cannot stall twice.
  assign bubble = stall | flush | ~ID_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IDEX_valid     <= 1'b0;
      IDEX_Rn        <= '0;
      IDEX_Rm        <= '0;
      IDEX_Rd        <= XZR;
      IDEX_ctrl      <= CTRL_BUBBLE;
      IDEX_ReadData1 <= '0;
      IDEX_ReadData2 <= '0;
      IDEX_Imm       <= '0;
    end else begin
      IDEX_valid     <= ~bubble;
      IDEX_ctrl      <= bubble ? CTRL_BUBBLE : ID_ctrl;
      IDEX_Rd        <= bubble ? XZR : ID_Rd;
      // Source numbers and operands load unconditionally; a bubble is
      // harmless because its control word is all zeros.
      IDEX_Rn        <= ID_Rn;
      IDEX_Rm        <= ID_Rm;
      IDEX_ReadData1 <= ID_ReadData1;
      IDEX_ReadData2 <= ID_ReadData2;
      IDEX_Imm       <= ID_Imm;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_ex_hazard_reg.md
ID_EX_HAZARD_REG -- requirements
Module: id_ex_hazard_reg

Interface
REQ-001 Parameter DATA_W, default 64, operand/immediate width.
REQ-002 Parameter CNT_W, default 16, width of each event counter.
REQ-003 Single clock domain; reset asynchronous, active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 ID_valid  input  1  ID stage holds a real instruction.
REQ-007 ID_Rn, ID_Rm, ID_Rd  input  5 each  decoded register numbers; ID_Rm is post-Reg2Loc second source (Rd for STUR).
REQ-008 ID_ctrl  input  8  packed control {RegWrite, MemWrite, MemRead, MemToReg, ALUSrc, ALUOp[2:0]}.
REQ-009 ID_ReadData1, ID_ReadData2, ID_Imm  input  DATA_W each  register-file reads and extended immediate.
REQ-010 flush  input  1  taken-branch squash from a later stage.
REQ-011 IDEX_valid, IDEX_Rn, IDEX_Rm, IDEX_Rd, IDEX_ctrl, IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm  output  widths as inputs  registered EX-stage copies; feed EX operand muxes and forwarding logic.
REQ-012 stall  output  1  combinational; holds PC and IF/ID register.
REQ-013 stall_count, flush_count  output  CNT_W each  event counters.

Function
REQ-014 Load-use hazard = IDEX_valid & IDEX_ctrl.MemRead & (IDEX_Rd != 31) & ID_valid & ((IDEX_Rd == ID_Rn) | (IDEX_Rd == ID_Rm)).
REQ-015 stall SHALL equal hazard & ~flush.
REQ-016 Normal cycle (no hazard, no flush): all IDEX_* outputs load the ID_* inputs at the next clk edge, latency 1.
REQ-017 Bubble cycle: IDEX_valid=0, IDEX_ctrl=0, IDEX_Rd=31; IDEX_Rn, IDEX_Rm, and data fields still load from ID.
REQ-018 A bubble SHALL be inserted when stall=1 or flush=1.
REQ-019 flush has priority: when flush and hazard coincide, a bubble is inserted, stall=0, and only flush_count increments.
REQ-020 Stall lasts exactly one cycle per load-use pair (bubble clears MemRead); the block SHALL never assert stall on two consecutive cycles for the same IF/ID contents.
REQ-021 ID_valid=0 SHALL load IDEX_valid=0 with ctrl zeroed and IDEX_Rd=31, without counting.
REQ-022 stall_count SHALL increment on each cycle stall=1 and saturate at all-ones.
REQ-023 flush_count SHALL increment on each cycle flush=1 and saturate at all-ones.
REQ-024 Rn/Rm equal to 31 SHALL never raise a hazard (covered by the IDEX_Rd != 31 term).

Reset
REQ-025 While reset=1, all outputs SHALL be 0 except IDEX_Rd=31, regardless of clk.
REQ-026 stall SHALL be 0 while reset=1 (IDEX_valid=0).
REQ-027 Reset asserted mid-stall SHALL immediately clear stall and counters; first edge after release performs a normal load.

Structure
REQ-028 cpu_pkg SHALL hold: XZR constant (5'd31), ctrl bit-index constants, ctrl packed typedef, and ALUOp encodings.
REQ-029 Combinational hazard logic SHALL be one sub-module, load_use_detect; registers and counters stay in the top.

Verification
REQ-030 LDUR X1 in EX (valid, MemRead, Rd=1), ID ADD Rn=1 Rm=2 -> stall=1 same cycle; next edge IDEX_valid=0, IDEX_ctrl=0, IDEX_Rd=31, stall_count=1; following cycle stall=0.
REQ-031 LDUR X31 in EX, ID Rn=31 -> stall=0, normal load.
REQ-032 Hazard and flush same cycle -> stall=0; bubble loaded; flush_count=1, stall_count=0.
REQ-033 STUR in ID with ID_Rm=5 behind LDUR Rd=5 -> stall=1.
REQ-034 Preload stall_count to 16'hFFFE, force 3 stalls -> counter reads 16'hFFFF, holds.
REQ-035 Assert reset between clock edges during stall -> outputs clear at once, IDEX_Rd=31, stall=0.
